gshare_pattern_history_table: RTL and testbench

- Dynamic direction-prediction storage that sits directly upstream of the branch predictor.
- Fetch presents a PC; the block returns a taken/not-taken prediction taken from a table of 2-bit saturating counters. The table index is the PC hashed with a speculative global history register (GHR).
- Execute writes resolved outcomes back to train the counters. On a mispredict, the GHR is restored from a checkpoint.
- The branch predictor consumes predict_taken together with the checkpoint fields and carries them down the pipe alongside the branch.

---
 rtl/gshare_pattern_history_table_pkg.sv | 33 +++
 rtl/gshare_pattern_history_table.sv | 90 +++++++++
 tb/tb_gshare_pattern_history_table.sv | 173 +++++++++++++++++
 3 files changed

// File: rtl/gshare_pattern_history_table_pkg.sv
`default_nettype none
// ============================================================================
// Module   : gshare_pkg
// Purpose  : Shared types and helpers for the gshare pattern history table.
// Revision : 1.0  initial release
// ============================================================================
package gshare_pkg;

    typedef enum logic [1:0] {
        STRONG_NT = 2'b00,
        WEAK_NT   = 2'b01,
        WEAK_T    = 2'b10,
        STRONG_T  = 2'b11
    } pht_counter_t;

    localparam pht_counter_t PHT_RESET_STATE = WEAK_NT;

    // Two-bit saturating counter step toward the resolved outcome.
    function automatic pht_counter_t next_counter(input pht_counter_t cur, input logic taken);
        pht_counter_t nxt;
        nxt = cur;
        case (cur)
            STRONG_NT: nxt = taken ? WEAK_NT  : STRONG_NT;
            WEAK_NT:   nxt = taken ? WEAK_T   : STRONG_NT;
            WEAK_T:    nxt = taken ? STRONG_T : WEAK_NT;
            STRONG_T:  nxt = taken ? STRONG_T : WEAK_T;
            default:   nxt = PHT_RESET_STATE;
        endcase
        return nxt;
    endfunction

endpackage
`default_nettype wire

// File: rtl/gshare_pattern_history_table.sv
`default_nettype none
// ============================================================================
// Module   : gshare_pattern_history_table
// Purpose  : PC^GHR indexed table of 2-bit counters with speculative history.
// Revision : 1.0  initial release
// ============================================================================
module gshare_pattern_history_table
    import gshare_pkg::*;
#(
    parameter int XLEN           = 32,
    parameter int PHT_INDEX_BITS = 6,
    parameter int GHR_BITS       = 6
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic                      lookup_valid,
    input  logic [XLEN-1:0]           lookup_pc,
    output logic                      predict_taken,
    output logic [PHT_INDEX_BITS-1:0] predict_index,
    output logic [GHR_BITS-1:0]       predict_ghr,
    input  logic                      update_valid,
    input  logic [PHT_INDEX_BITS-1:0] update_index,
    input  logic                      update_taken,
    input  logic                      update_mispredict,
    input  logic [GHR_BITS-1:0]       update_ghr,
    output logic [GHR_BITS-1:0]       ghr
);

    localparam int PHT_ENTRIES = 1 << PHT_INDEX_BITS;

    generate
        if (GHR_BITS > PHT_INDEX_BITS) begin : g_bad_ghr_width
            $error("GHR_BITS must not exceed PHT_INDEX_BITS");
        end
    endgenerate

    pht_counter_t              pht_q [PHT_ENTRIES];
    pht_counter_t              pht_d [PHT_ENTRIES];
    logic [GHR_BITS-1:0]       ghr_q;
    logic [GHR_BITS-1:0]       ghr_d;
    logic [PHT_INDEX_BITS-1:0] ghr_ext;
    logic [PHT_INDEX_BITS-1:0] lookup_index;

    logic unused_bits;
    assign unused_bits = ^{lookup_pc[XLEN-1:PHT_INDEX_BITS+2], lookup_pc[1:0],
                           update_ghr[GHR_BITS-1]};

    // A short history only folds into the low index bits.
    always_comb begin
        ghr_ext                 = '0;
        ghr_ext[GHR_BITS-1:0]   = ghr_q;
        lookup_index            = lookup_pc[PHT_INDEX_BITS+1:2] ^ ghr_ext;
    end

    assign predict_index = lookup_index;
    assign predict_taken = pht_q[lookup_index][1];
    assign predict_ghr   = ghr_q;
    assign ghr           = ghr_q;

    always_comb begin
        pht_d = pht_q;
        if (update_valid) begin
            pht_d[update_index] = next_counter(pht_q[update_index], update_taken);
        end
    end

    // Recovery overrides the speculative shift: a same-cycle lookup is wrong-path.
    always_comb begin
        ghr_d = ghr_q;
        if (update_valid && update_mispredict) begin
            ghr_d = {update_ghr[GHR_BITS-2:0], update_taken};
        end else if (lookup_valid) begin
            ghr_d = {ghr_q[GHR_BITS-2:0], predict_taken};
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < PHT_ENTRIES; i++) begin
                pht_q[i] <= PHT_RESET_STATE;
            end
            ghr_q <= '0;
        end else begin
            pht_q <= pht_d;
            ghr_q <= ghr_d;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_gshare_pattern_history_table.sv
`default_nettype none
// ============================================================================
// Module   : tb_gshare_pattern_history_table
// Purpose  : Directed self-checking bench for gshare_pattern_history_table.
// Revision : 1.0  initial release
// ============================================================================
module tb_gshare_pattern_history_table;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        lookup_valid;
    logic [31:0] lookup_pc;
    logic        predict_taken;
    logic [5:0]  predict_index;
    logic [5:0]  predict_ghr;
    logic        update_valid;
    logic [5:0]  update_index;
    logic        update_taken;
    logic        update_mispredict;
    logic [5:0]  update_ghr;
    logic [5:0]  ghr;

    int errors = 0;
    int checks = 0;

    gshare_pattern_history_table #(
        .XLEN(32), .PHT_INDEX_BITS(6), .GHR_BITS(6)
    ) dut (
        .clk(clk), .reset_n(reset_n),
        .lookup_valid(lookup_valid), .lookup_pc(lookup_pc),
        .predict_taken(predict_taken), .predict_index(predict_index),
        .predict_ghr(predict_ghr),
        .update_valid(update_valid), .update_index(update_index),
        .update_taken(update_taken), .update_mispredict(update_mispredict),
        .update_ghr(update_ghr), .ghr(ghr)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic train(input logic [5:0] idx, input logic taken);
        update_valid      = 1'b1;
        update_mispredict = 1'b0;
        update_index      = idx;
        update_taken      = taken;
        tick();
        update_valid      = 1'b0;
    endtask

    task automatic recover(input logic [5:0] chk, input logic taken, input logic [5:0] idx);
        update_valid      = 1'b1;
        update_mispredict = 1'b1;
        update_ghr        = chk;
        update_taken      = taken;
        update_index      = idx;
        tick();
        update_valid      = 1'b0;
        update_mispredict = 1'b0;
    endtask

    logic [5:0] exp_idx [7];

    initial begin
        reset_n = 1'b0; lookup_valid = 1'b0; lookup_pc = 32'h10;
        update_valid = 1'b0; update_index = '0; update_taken = 1'b0;
        update_mispredict = 1'b0; update_ghr = '0;
        #2;
        check("rst_taken", predict_taken, 0);
        check("rst_index", predict_index, 4);
        check("rst_pghr",  predict_ghr, 0);
        check("rst_ghr",   ghr, 0);
        @(negedge clk); @(negedge clk);
        reset_n = 1'b1;
        tick();

        // First lookup after reset.
        lookup_valid = 1'b1; lookup_pc = 32'h10; #1;
        check("lk0_taken", predict_taken, 0);
        check("lk0_index", predict_index, 4);
        check("lk0_pghr",  predict_ghr, 0);
        tick();
        lookup_valid = 1'b0;
        check("lk0_ghr", ghr, 0);

        // Saturation at both ends for index 4.
        train(6'd4, 1'b1); train(6'd4, 1'b1);
        check("sat_11", predict_taken, 1);
        train(6'd4, 1'b1); train(6'd4, 1'b1);
        check("sat_hold11", predict_taken, 1);
        train(6'd4, 1'b0);
        check("nt_to_10", predict_taken, 1);
        train(6'd4, 1'b0);
        check("nt_to_01", predict_taken, 0);
        train(6'd4, 1'b0); train(6'd4, 1'b0);
        train(6'd4, 1'b1);
        check("sat_hold00", predict_taken, 0);
        train(6'd4, 1'b1);
        check("up_to_10", predict_taken, 1);

        // Train every index the all-taken history walk will visit.
        exp_idx = '{6'd4, 6'd5, 6'd7, 6'd3, 6'd11, 6'd27, 6'd59};
        for (int i = 0; i < 7; i++) begin
            train(exp_idx[i], 1'b1); train(exp_idx[i], 1'b1);
        end
        lookup_valid = 1'b1; lookup_pc = 32'h10;
        for (int i = 0; i < 7; i++) begin
            #1;
            check($sformatf("walk%0d_index", i), predict_index, exp_idx[i]);
            check($sformatf("walk%0d_taken", i), predict_taken, 1);
            tick();
            check($sformatf("walk%0d_ghr", i), ghr, (i >= 5) ? 63 : ((1 << (i + 1)) - 1));
        end
        lookup_valid = 1'b0;

        // Recovery beats a same-cycle lookup shift.
        recover(6'b010101, 1'b0, 6'd20);
        check("spec_ghr", ghr, 6'b101010);
        lookup_valid = 1'b1;
        recover(6'b000011, 1'b0, 6'd20);
        lookup_valid = 1'b0;
        check("recover_ghr", ghr, 6'b000110);

        // Same-index update and lookup: no bypass.
        lookup_valid = 1'b1; lookup_pc = 32'h3C;
        update_valid = 1'b1; update_mispredict = 1'b0;
        update_index = 6'd9; update_taken = 1'b1;
        #1;
        check("byp_index", predict_index, 9);
        check("byp_taken", predict_taken, 0);
        tick();
        update_valid = 1'b0; lookup_valid = 1'b0;
        check("byp_ghr", ghr, 6'b001100);
        lookup_pc = 32'h14; #1;
        check("post_index", predict_index, 9);
        check("post_taken", predict_taken, 1);

        // Asynchronous reset between edges clears training and history.
        @(posedge clk); #2;
        reset_n = 1'b0; #1;
        check("arst_ghr",  ghr, 0);
        check("arst_pghr", predict_ghr, 0);
        for (int i = 0; i < 64; i++) begin
            lookup_pc = 32'(i << 2); #1;
            check($sformatf("arst_idx%0d", i), predict_index, i);
            check($sformatf("arst_tk%0d", i), predict_taken, 0);
        end
        reset_n = 1'b1;
        tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1);
    end

endmodule
`default_nettype wire
